// File: rtl/hough_pkg.sv
// Shared Hough lane-path types and default image geometry.
// Used by edge_point_extractor and by the Hough voter (hough_point_t).
package hough_pkg;
  localparam int WIDTH  = 568;
  localparam int HEIGHT = 320;
  localparam int X_W    = $clog2(WIDTH);
  localparam int Y_W    = $clog2(HEIGHT);
  localparam int CNT_W  = $clog2(WIDTH*HEIGHT+1);
  localparam logic [7:0] THRESHOLD_RST = 8'd64;

  typedef struct packed {
    logic           eof;
    logic [Y_W-1:0] y;
    logic [X_W-1:0] x;
  } hough_point_t;

  typedef enum logic [1:0] {READ, EMIT, EOF_MARK} ep_state_t;
endpackage

// File: rtl/edge_point_extractor.sv
// Pops Sobel magnitudes in raster order, thresholds them and pushes (x,y) edge points plus one EOF word per frame.
// Optional region-of-interest gating is built only when ROI_EN is defined.
module edge_point_extractor #(
  parameter int WIDTH  = hough_pkg::WIDTH,
  parameter int HEIGHT = hough_pkg::HEIGHT,
  parameter logic [7:0] THRESHOLD_RST = hough_pkg::THRESHOLD_RST,
`ifdef ROI_EN
  parameter int ROI_X0 = 0,
  parameter int ROI_X1 = WIDTH-1,
  parameter int ROI_Y0 = 0,
  parameter int ROI_Y1 = HEIGHT-1,
`endif
  localparam int X_W   = $clog2(WIDTH),
  localparam int Y_W   = $clog2(HEIGHT),
  localparam int CNT_W = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             in_rd_en,
  input  logic             in_empty,
  input  logic [7:0]       in_dout,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic [X_W+Y_W:0] out_din,
  input  logic [7:0]       threshold,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_edge_count
);
  import hough_pkg::*;

  localparam logic [X_W-1:0]   COL_LAST = X_W'(WIDTH-1);
  localparam logic [Y_W-1:0]   ROW_LAST = Y_W'(HEIGHT-1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH*HEIGHT);

  ep_state_t        state, state_n;
  logic [X_W-1:0]   col, col_n, pt_x, pt_x_n;
  logic [Y_W-1:0]   row, row_n, pt_y, pt_y_n;
  logic             last, last_n;
  logic [7:0]       thr_q, thr_n;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_n, fec_n;
  logic             at_end, in_roi, hit;

  assign at_end = (row == ROW_LAST) && (col == COL_LAST);

`ifdef ROI_EN
  assign in_roi = (col >= X_W'(ROI_X0)) && (col <= X_W'(ROI_X1)) &&
                  (row >= Y_W'(ROI_Y0)) && (row <= Y_W'(ROI_Y1));
`else
  assign in_roi = 1'b1;
`endif

  assign hit = (in_dout >= thr_q) && in_roi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= READ;
    else       state <= state_n;
  end

  // out_din is forced to zero whenever no word is being pushed.
  always_comb begin
    state_n    = state;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = '0;
    frame_done = 1'b0;
    case (state)
      READ: begin
        in_rd_en = !in_empty && !reset;
        if (in_rd_en) begin
          if (hit)         state_n = EMIT;
          else if (at_end) state_n = EOF_MARK;
        end
      end
      EMIT: begin
        out_wr_en = !out_full;
        if (out_wr_en) begin
          out_din = {1'b0, pt_y, pt_x};
          state_n = last ? EOF_MARK : READ;
        end
      end
      EOF_MARK: begin
        out_wr_en = !out_full;
        if (out_wr_en) begin
          out_din    = {1'b1, {(X_W+Y_W){1'b0}}};
          frame_done = 1'b1;
          state_n    = READ;
        end
      end
      default: state_n = READ;
    endcase
  end

  always_comb begin
    col_n      = col;
    row_n      = row;
    pt_x_n     = pt_x;
    pt_y_n     = pt_y;
    last_n     = last;
    thr_n      = thr_q;
    edge_cnt_n = edge_cnt;
    fec_n      = frame_edge_count;
    if (in_rd_en) begin
      pt_x_n = col;
      pt_y_n = row;
      last_n = at_end;
      if (col == COL_LAST) begin
        col_n = '0;
        row_n = row + 1'b1;
      end else begin
        col_n = col + 1'b1;
      end
    end
    if (out_wr_en && (state == EMIT) && (edge_cnt != CNT_MAX))
      edge_cnt_n = edge_cnt + 1'b1;
    // Frame boundary: publish the count and pick up the new threshold.
    if (frame_done) begin
      fec_n      = edge_cnt;
      edge_cnt_n = '0;
      row_n      = '0;
      col_n      = '0;
      thr_n      = threshold;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col              <= '0;
      row              <= '0;
      pt_x             <= '0;
      pt_y             <= '0;
      last             <= 1'b0;
      thr_q            <= THRESHOLD_RST;
      edge_cnt         <= '0;
      frame_edge_count <= '0;
    end else begin
      col              <= col_n;
      row              <= row_n;
      pt_x             <= pt_x_n;
      pt_y             <= pt_y_n;
      last             <= last_n;
      thr_q            <= thr_n;
      edge_cnt         <= edge_cnt_n;
      frame_edge_count <= fec_n;
    end
  end
endmodule
